// File: rtl/vm_pkg.sv
// Shared definitions for the text-mode video memory writer and display reader.
// Contents: screen geometry, circular buffer size, ASCII control codes,
// E0-extended arrow scan codes and the writer FSM state type.
package vm_pkg;

    localparam int COLS     = 70;
    localparam int ROWS     = 30;
    localparam int BUF_ROWS = 64;
    localparam int BUF_SIZE = COLS * BUF_ROWS;  // 4480 cells

    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        WRITE   = 2'd2,
        CLR_ROW = 2'd3
    } state_t;

endpackage

// File: rtl/vm_addr_calc.sv
// Combinational cell address for the circular video memory:
//   addr = (roll + y*COLS + x) mod BUF_SIZE
// roll < BUF_SIZE and y*COLS + x < ROWS*COLS, so one conditional subtract
// brings the 14-bit sum back into range.
// Ports: roll (buffer offset of top visible row), x (column), y (visible row),
//        addr (wrapped video-memory address).
module vm_addr_calc
    import vm_pkg::*;
#(
    parameter int COLS     = vm_pkg::COLS,
    parameter int BUF_SIZE = vm_pkg::BUF_SIZE
) (
    input  logic [12:0] roll,
    input  logic [6:0]  x,
    input  logic [4:0]  y,
    output logic [12:0] addr
);

    logic [13:0] sum;

    always_comb begin
        sum  = 14'(roll) + 14'(y) * 14'(COLS) + 14'(x);
        addr = (sum >= 14'(BUF_SIZE)) ? 13'(sum - 14'(BUF_SIZE)) : sum[12:0];
    end

endmodule

// File: rtl/vm_text_writer.sv
// Text-mode writer: accepts ASCII bytes, maintains the cursor and writes
// characters into a circular video memory, scrolling by advancing roll_cnt
// and blanking the newly exposed bottom row. After reset the whole buffer
// is blanked.
// Ports: clk, reset (sync, active-high); char_valid/char_data/char_ready
//        byte handshake; dir_valid/dir_code arrow-key pulse; vm_we/vm_waddr/
//        vm_wdata memory write port; cursor_x/cursor_y cursor position;
//        roll_cnt top-row buffer offset; busy during clear/scroll.
// Build option: define VM_WRITER_ARROW_EN to let arrow keys move the cursor.
module vm_text_writer
    import vm_pkg::*;
#(
    parameter int COLS     = vm_pkg::COLS,
    parameter int ROWS     = vm_pkg::ROWS,
    parameter int BUF_ROWS = vm_pkg::BUF_ROWS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        dir_valid,
    input  logic [7:0]  dir_code,
    output logic        vm_we,
    output logic [12:0] vm_waddr,
    output logic [7:0]  vm_wdata,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic [12:0] roll_cnt,
    output logic        busy
);

    localparam int          WRAP        = COLS * BUF_ROWS;
    localparam logic [6:0]  X_MAX       = 7'(COLS - 1);
    localparam logic [4:0]  Y_MAX       = 5'(ROWS - 1);
    localparam logic [12:0] CLR_ALL_END = 13'(WRAP);
    localparam logic [12:0] CLR_ROW_END = 13'(COLS);

    state_t      state;
    logic [12:0] clr_cnt;
    logic [7:0]  byte_q;
    logic        accept;
    logic        scroll;
    logic        bs_move;
    logic [6:0]  bs_x;
    logic [4:0]  bs_y;
    logic [6:0]  calc_x;
    logic [4:0]  calc_y;
    logic [12:0] calc_addr;
    logic [13:0] roll_sum;
    logic [12:0] roll_next;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign char_ready = (state == IDLE);
    assign accept     = char_valid && char_ready;

    // Backspace target: one cell back, wrapping to the end of the previous row.
    assign bs_move = (cursor_x != 7'd0) || (cursor_y != 5'd0);
    assign bs_x    = (cursor_x != 7'd0) ? cursor_x - 7'd1 : X_MAX;
    assign bs_y    = (cursor_x != 7'd0) ? cursor_y : cursor_y - 5'd1;

    // Evaluated in WRITE, where byte_q and the cursor are those of the accepted byte.
    assign scroll = (cursor_y == Y_MAX) &&
                    ((is_printable(byte_q) && cursor_x == X_MAX) || byte_q == ASCII_CR);

    assign busy = (state == CLR_ALL) || (state == CLR_ROW) || (state == WRITE && scroll);

    assign roll_sum  = {1'b0, roll_cnt} + 14'(COLS);
    assign roll_next = (roll_sum >= 14'(WRAP)) ? 13'(roll_sum - 14'(WRAP)) : roll_sum[12:0];

    // The single address calculator is shared between the row clear and
    // the character/backspace write, which never occur in the same state.
    always_comb begin
        calc_x = cursor_x;
        calc_y = cursor_y;
        if (state == CLR_ROW) begin
            calc_x = clr_cnt[6:0];
            calc_y = Y_MAX;
        end else if (char_data == ASCII_BS) begin
            calc_x = bs_x;
            calc_y = bs_y;
        end
    end

    vm_addr_calc #(
        .COLS     (COLS),
        .BUF_SIZE (WRAP)
    ) u_addr_calc (
        .roll (roll_cnt),
        .x    (calc_x),
        .y    (calc_y),
        .addr (calc_addr)
    );

`ifndef VM_WRITER_ARROW_EN
    logic unused_dir;
    assign unused_dir = dir_valid ^ (^dir_code);
`endif

    // Clear states present their last write while still in the clear state,
    // so busy covers every clear write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLR_ALL;
            clr_cnt  <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            roll_cnt <= '0;
            vm_we    <= 1'b0;
        end else begin
            vm_we <= 1'b0;
            case (state)
                CLR_ALL: begin
                    if (clr_cnt == CLR_ALL_END) begin
                        state <= IDLE;
                    end else begin
                        vm_we    <= 1'b1;
                        vm_waddr <= clr_cnt;
                        vm_wdata <= ASCII_SP;
                        clr_cnt  <= clr_cnt + 13'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        byte_q <= char_data;
                        state  <= WRITE;
                        if (is_printable(char_data) || (char_data == ASCII_BS && bs_move)) begin
                            vm_we    <= 1'b1;
                            vm_waddr <= calc_addr;
                            vm_wdata <= (char_data == ASCII_BS) ? ASCII_SP : char_data;
                        end
                    end
`ifdef VM_WRITER_ARROW_EN
                    else if (dir_valid) begin
                        case (dir_code)
                            SC_UP:    if (cursor_y != 5'd0) cursor_y <= cursor_y - 5'd1;
                            SC_DOWN:  if (cursor_y != Y_MAX) cursor_y <= cursor_y + 5'd1;
                            SC_LEFT:  if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                            SC_RIGHT: if (cursor_x != X_MAX) cursor_x <= cursor_x + 7'd1;
                            default:  ;
                        endcase
                    end
`endif
                end
                WRITE: begin
                    state <= IDLE;
                    if (is_printable(byte_q)) begin
                        if (cursor_x != X_MAX) begin
                            cursor_x <= cursor_x + 7'd1;
                        end else begin
                            cursor_x <= '0;
                            if (cursor_y != Y_MAX) cursor_y <= cursor_y + 5'd1;
                        end
                    end else if (byte_q == ASCII_CR) begin
                        cursor_x <= '0;
                        if (cursor_y != Y_MAX) cursor_y <= cursor_y + 5'd1;
                    end else if (byte_q == ASCII_BS && bs_move) begin
                        cursor_x <= bs_x;
                        cursor_y <= bs_y;
                    end
                    if (scroll) begin
                        roll_cnt <= roll_next;
                        clr_cnt  <= '0;
                        state    <= CLR_ROW;
                    end
                end
                CLR_ROW: begin
                    if (clr_cnt == CLR_ROW_END) begin
                        state <= IDLE;
                    end else begin
                        vm_we    <= 1'b1;
                        vm_waddr <= calc_addr;
                        vm_wdata <= ASCII_SP;
                        clr_cnt  <= clr_cnt + 13'd1;
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_text_writer.sv
// Bench for vm_text_writer: stimulus pushes expected memory writes into a
// queue, a negedge monitor pops and compares every vm_we cycle.
module tb_vm_text_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        dir_valid = 1'b0;
    logic [7:0]  dir_code = 8'h00;
    logic        vm_we;
    logic [12:0] vm_waddr;
    logic [7:0]  vm_wdata;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [12:0] roll_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];

    int mx = 0, my = 0, mroll = 0;

    vm_text_writer dut (
        .clk(clk), .reset(reset),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .dir_valid(dir_valid), .dir_code(dir_code),
        .vm_we(vm_we), .vm_waddr(vm_waddr), .vm_wdata(vm_wdata),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .roll_cnt(roll_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (vm_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", vm_waddr, vm_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (vm_waddr !== e.a || vm_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             vm_waddr, vm_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back({13'(a), d});
    endtask

    function automatic int maddr(input int x, input int y);
        return (mroll + y * 70 + x) % 4480;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (char_ready !== 1'b1 && n < 10000) begin
            @(posedge clk); #1; n++;
        end
        if (char_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_idle timeout got=%b want=1", char_ready);
        end
    endtask

    // Presents one byte while idle; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        wait_idle();
        char_valid = 1'b1;
        char_data  = b;
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic dir_pulse(input logic [7:0] c);
        wait_idle();
        dir_valid = 1'b1;
        dir_code  = c;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        wait_idle();
    endtask

    task automatic mscroll();
        mroll = (mroll + 70) % 4480;
        for (int i = 0; i < 70; i++) push(maddr(i, 29), 8'h20);
    endtask

    task automatic model_advance();
        if (mx == 69) begin
            mx = 0;
            if (my == 29) mscroll(); else my++;
        end else mx++;
    endtask

    // Sends a byte and pushes what the reference model expects it to write.
    task automatic send_m(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(maddr(mx, my), b);
            model_advance();
        end else if (b == 8'h0D) begin
            mx = 0;
            if (my == 29) mscroll(); else my++;
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--; push(maddr(mx, my), 8'h20);
            end else if (my > 0) begin
                mx = 69; my--; push(maddr(mx, my), 8'h20);
            end
        end
        send(b);
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_cursor_x", int'(cursor_x), 0);
        chk("rst_cursor_y", int'(cursor_y), 0);
        chk("rst_roll_cnt", int'(roll_cnt), 0);
        chk("rst_vm_we", int'(vm_we), 0);
        chk("rst_char_ready", int'(char_ready), 0);
        chk("rst_busy", int'(busy), 1);
        reset = 1'b0;
        mx = 0; my = 0; mroll = 0;
        for (int i = 0; i < 4480; i++) push(i, 8'h20);
        wait_idle();
        chk("clr_all_busy", int'(busy), 0);
        chk("clr_all_ready", int'(char_ready), 1);
        chk("clr_all_remaining", exp_q.size(), 0);
    endtask

    task automatic chk_cursor(input string name, input int x, input int y);
        chk({name, "_x"}, int'(cursor_x), x);
        chk({name, "_y"}, int'(cursor_y), y);
    endtask

    initial begin
        #1;
        do_reset();

        // 'A' at (0,0): written on the cycle after acceptance.
        push(0, 8'h41);
        send(8'h41);
        chk("a_we", int'(vm_we), 1);
        chk("a_addr", int'(vm_waddr), 0);
        chk("a_data", int'(vm_wdata), 8'h41);
        wait_idle();
        chk_cursor("a_cur", 1, 0);
        mx = 1;

        // Walk to (69,29).
        for (int i = 0; i < 29; i++) send_m(8'h0D);
        for (int i = 0; i < 69; i++) send_m(8'h61 + 8'(i % 26));
        chk_cursor("pre_scroll", 69, 29);
        chk("pre_scroll_roll", int'(roll_cnt), 0);

        // 'B' at the last cell scrolls: write 2099 then blank 2100..2169.
        push(2099, 8'h42);
        for (int i = 0; i < 70; i++) push(2100 + i, 8'h20);
        send(8'h42);
        chk("scroll_busy", int'(busy), 1);
        chk("scroll_ready", int'(char_ready), 0);
        wait_idle();
        chk("scroll_roll", int'(roll_cnt), 70);
        chk_cursor("scroll_cur", 0, 29);
        chk("scroll_remaining", exp_q.size(), 0);
        mx = 0; my = 29; mroll = 70;

        // Scroll up to roll_cnt 4410, then one CR wraps it to 0.
        for (int i = 0; i < 62; i++) send_m(8'h0D);
        chk("roll_4410", int'(roll_cnt), 4410);
        for (int i = 0; i < 70; i++) push(2030 + i, 8'h20);
        send(8'h0D);
        chk("cr_no_write", int'(vm_we), 0);
        wait_idle();
        chk("wrap_roll", int'(roll_cnt), 0);
        chk_cursor("wrap_cur", 0, 29);
        chk("wrap_remaining", exp_q.size(), 0);
        mroll = 0; mx = 0; my = 29;

        send_m(8'h0D);
        chk("roll_70_again", int'(roll_cnt), 70);
        do_reset();

        // Backspace at (0,5) goes to (69,4) and blanks address 349.
        for (int i = 0; i < 5; i++) send_m(8'h0D);
        push(349, 8'h20);
        send(8'h08);
        chk("bs_addr", int'(vm_waddr), 349);
        wait_idle();
        chk_cursor("bs_cur", 69, 4);
        mx = 69; my = 4;

        for (int i = 0; i < 349; i++) send_m(8'h08);
        chk_cursor("bs_home", 0, 0);
        send(8'h08);
        chk("bs_origin_no_write", int'(vm_we), 0);
        wait_idle();
        chk_cursor("bs_origin_cur", 0, 0);

        // Printable range boundaries and discarded bytes.
        send_m(8'h7E);
        send_m(8'h7F);
        send_m(8'h01);
        send_m(8'h20);
        chk_cursor("bounds_cur", 2, 0);
        chk("bounds_remaining", exp_q.size(), 0);

        // Arrow keys.
        send_m(8'h0D); send_m(8'h0D); send_m(8'h0D);
        chk_cursor("at_0_3", 0, 3);
        dir_pulse(8'h6B);
        chk_cursor("left_sat", 0, 3);
        dir_pulse(8'h74);
`ifdef VM_WRITER_ARROW_EN
        chk_cursor("right", 1, 3);
        mx = 1;
`else
        chk_cursor("right_ignored", 0, 3);
`endif
        dir_pulse(8'h72);
`ifdef VM_WRITER_ARROW_EN
        chk_cursor("down", 1, 4);
        my = 4;
`else
        chk_cursor("down_ignored", 0, 3);
`endif

        // Character and arrow together: only the character takes effect.
        push(maddr(mx, my), 8'h43);
        model_advance();
        wait_idle();
        char_valid = 1'b1; char_data = 8'h43;
        dir_valid  = 1'b1; dir_code  = 8'h74;
        @(posedge clk); #1;
        char_valid = 1'b0; dir_valid = 1'b0;
        wait_idle();
        chk_cursor("char_over_dir", mx, my);

        repeat (3) @(posedge clk);
        #1;
        chk("final_remaining", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vm_text_writer.md
VM_TEXT_WRITER -- requirements
Module: vm_text_writer

Interface
REQ-001 Parameters (name, default, meaning): COLS, 70, text columns per row; ROWS, 30, visible rows; BUF_ROWS, 64, rows held in the circular video-memory buffer.
REQ-002 Ports (name, direction, width, meaning):
- clk in 1: single clock.
- reset in 1: synchronous, active-high.
- char_valid in 1: an ASCII byte is offered.
- char_data in 8: ASCII byte.
- char_ready out 1: the writer accepts a byte this cycle.
- dir_valid in 1: one-cycle arrow-key pulse.
- dir_code in 8: E0-extended scan code (75 up, 72 down, 6B left, 74 right).
- vm_we out 1: video-memory write strobe.
- vm_waddr out 13: video-memory write address.
- vm_wdata out 8: ASCII byte to store.
- cursor_x out 7: cursor column.
- cursor_y out 5: cursor visible row.
- roll_cnt out 13: buffer offset of the top visible row, for the display reader.
- busy out 1: a clear or scroll operation is in progress.

Function
REQ-003 A transfer SHALL occur when char_valid and char_ready are both high at a clk edge; char_ready SHALL be high only in state IDLE.
REQ-004 FSM states SHALL be CLR_ALL, IDLE, WRITE, CLR_ROW.
- Reset enters CLR_ALL.
- CLR_ALL goes to IDLE after its last write.
- IDLE goes to WRITE on a transfer.
- WRITE goes to IDLE, or to CLR_ROW on scroll.
- CLR_ROW goes to IDLE after COLS writes.
REQ-005 The address SHALL be computed as addr(x,y) = (roll_cnt + y*COLS + x) mod (BUF_ROWS*COLS = 4480), using at least 14-bit intermediate width and a single conditional subtract of 4480.
REQ-006 A printable byte (0x20-0x7E) SHALL produce vm_we=1 with vm_wdata=byte and vm_waddr=addr(cursor_x,cursor_y) exactly one cycle after acceptance, then advance cursor_x.
- At cursor_x=COLS-1 the cursor SHALL wrap to column 0 of the next row, scrolling if needed.
REQ-007 Byte 0x0D SHALL set cursor_x=0 and cursor_y+1, scrolling if cursor_y=ROWS-1; no write.
REQ-008 Byte 0x08 (backspace) SHALL first move the cursor back, then write 0x20 at the new position.
- Back one column when cursor_x>0.
- To (COLS-1, cursor_y-1) when cursor_x=0 and cursor_y>0.
- No move and no write at (0,0).
REQ-009 Any other byte SHALL be accepted and discarded with no write and no cursor change.
REQ-010 Scroll SHALL perform these steps:
- roll_cnt += COLS mod 4480; cursor_y stays ROWS-1, cursor_x=0.
- Then CLR_ROW writes 0x20 to addr(0..COLS-1, ROWS-1), one per cycle, in ascending column order.
- busy=1 throughout; char_ready=0 throughout.
REQ-011 CLR_ALL SHALL write 0x20 to addresses 0..4479 ascending, one per cycle, with busy=1.
REQ-012 vm_we SHALL be high only on the write cycles defined above; vm_waddr and vm_wdata are don't-care when vm_we=0.
REQ-013 If a transfer and dir_valid occur in the same cycle, the character SHALL take priority and the dir pulse SHALL be dropped; dir_valid outside IDLE SHALL be ignored.

Reset
REQ-014 While reset is high at a clk edge, the block SHALL set outputs as follows:
- cursor_x=0, cursor_y=0, roll_cnt=0.
- vm_we=0, char_ready=0, busy=1.
- State CLR_ALL, with the clear counter at 0.
REQ-015 Reset asserted mid-operation (WRITE, CLR_ROW, CLR_ALL) SHALL abort it immediately; the in-flight byte is lost.

Configuration
REQ-016 With VM_WRITER_ARROW_EN defined, a dir_valid pulse in IDLE SHALL move the cursor one cell in the coded direction, saturating at the borders (0..COLS-1, 0..ROWS-1), with no write and no scroll; other dir_code values SHALL be ignored.
REQ-017 Without VM_WRITER_ARROW_EN, dir_valid and dir_code SHALL be ignored; the ports remain present.

Structure
REQ-018 The following SHALL live in the shared package vm_pkg, for use by both this writer and the display reader:
- COLS, ROWS, BUF_ROWS, BUF_SIZE=4480.
- ASCII constants 0x08, 0x0D, 0x20.
- Arrow scan-code constants.
- The FSM state enum.
REQ-019 Address wrap arithmetic (REQ-005) SHALL be a sub-module vm_addr_calc, combinational, instantiated once.

Verification
REQ-020 The bench SHALL cover:
- Reset held 1 cycle then released -> 4480 consecutive vm_we writes of 0x20 at addresses 0..4479, then char_ready=1, busy=0.
- Send 'A'(0x41) at (0,0) -> next cycle vm_we=1, vm_waddr=0, vm_wdata=0x41; cursor_x=1.
- Cursor (69,29), roll_cnt=0, send 'B' -> write at addr 2099; roll_cnt=70; 70 writes of 0x20 at 2100..2169; cursor (0,29).
- roll_cnt=4410, send 0x0D at row 29 -> roll_cnt=0; clear writes addresses 2030..2099 (wrapped).
- Backspace at (0,5) -> cursor (69,4), write 0x20 at addr 349; backspace at (0,0) -> no write.
- With VM_WRITER_ARROW_EN: dir 0x6B at (0,3) -> cursor stays (0,3); dir 0x74 with a simultaneous char -> char written, cursor advanced by one only.
